// File: rtl/counter_share_arbiter.sv
`default_nettype none
// ============================================================================
// counter_share_arbiter : round-robin sharing of one W-bit up-counter by N
// requesters, each counting 0..LIMIT[i].           Revision: 1.0
// ============================================================================
module counter_share_arbiter #(
   parameter int N  = 4,
   parameter int W  = 4,
   parameter int IW = 2
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [N-1:0]   REQ,
   input  logic [N*W-1:0] LIMIT,
   output logic [N-1:0]   GNT,
   output logic [N-1:0]   DONE,
   output logic [W-1:0]   QOUT,
   output logic [IW-1:0]  OWNER,
   output logic           BUSY
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  gnt_q;
   logic [N-1:0]  done_q;
   logic [W-1:0]  qout_q;
   logic [W-1:0]  lim_q;
   logic [IW-1:0] owner_q;
   logic [IW-1:0] ptr_q;
   logic          busy_q;

   logic [IW-1:0] win_d;
   logic          found_d;
   logic [IW-1:0] ptr_d;
   logic [W-1:0]  win_lim_d;

   // Rotating priority search starting at the round-robin pointer.
   always_comb begin
      win_d   = '0;
      found_d = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found_d && REQ[(int'(ptr_q) + k) % N]) begin
            win_d   = IW'((int'(ptr_q) + k) % N);
            found_d = 1'b1;
         end
      end
   end

   assign ptr_d     = (int'(win_d) == N - 1) ? '0 : win_d + 1'b1;
   assign win_lim_d = LIMIT[int'(win_d)*W +: W];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         qout_q  <= '0;
         lim_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= '0;
               if (found_d) begin
                  lim_q   <= win_lim_d;
                  qout_q  <= '0;
                  gnt_q   <= N'(1) << win_d;
                  owner_q <= win_d;
                  ptr_q   <= ptr_d;
                  busy_q  <= 1'b1;
                  state_q <= COUNT;
               end
            end
            COUNT: begin
               // An abort outranks terminal detection, so a dropped request never earns DONE.
               if (!REQ[owner_q]) begin
                  gnt_q   <= '0;
                  state_q <= RELEASE;
               end else if (qout_q == lim_q) begin
                  done_q  <= N'(1) << owner_q;
                  gnt_q   <= '0;
                  state_q <= RELEASE;
               end else begin
                  qout_q <= qout_q + 1'b1;
               end
            end
            RELEASE: begin
               done_q  <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               gnt_q   <= '0;
               done_q  <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign GNT   = gnt_q;
   assign DONE  = done_q;
   assign QOUT  = qout_q;
   assign OWNER = owner_q;
   assign BUSY  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_counter_share_arbiter : directed self-checking bench for the shared
// counter arbiter.                                  Revision: 1.0
// ============================================================================
module tb_counter_share_arbiter;
   localparam int N  = 4;
   localparam int W  = 4;
   localparam int IW = 2;

   logic           CLK;
   logic           RESET;
   logic [N-1:0]   REQ;
   logic [N*W-1:0] LIMIT;
   logic [N-1:0]   GNT;
   logic [N-1:0]   DONE;
   logic [W-1:0]   QOUT;
   logic [IW-1:0]  OWNER;
   logic           BUSY;

   int n_cmp = 0;
   int n_err = 0;

   // Observed vector layout: {GNT, DONE, QOUT, OWNER, BUSY}
   logic [14:0] obs;
   assign obs = {GNT, DONE, QOUT, OWNER, BUSY};

   counter_share_arbiter #(.N(N), .W(W), .IW(IW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .REQ   (REQ),
      .LIMIT (LIMIT),
      .GNT   (GNT),
      .DONE  (DONE),
      .QOUT  (QOUT),
      .OWNER (OWNER),
      .BUSY  (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic test_reset();
      logic [14:0] e;
      RESET = 1'b0;
      REQ   = 4'b1111;
      LIMIT = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         e = {4'b0000, 4'b0000, 4'd0, 2'd0, 1'b0};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset c%0d: got %b expected %b {gnt,done,q,own,busy}", c, obs, e);
         end
      end
      REQ   = '0;
      RESET = 1'b1;
   endtask

   task automatic test_single();
      logic [14:0] e;
      LIMIT = {4'd0, 4'd0, 4'd0, 4'd3};
      REQ   = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         e = {4'b0001, 4'b0000, 4'(i), 2'd0, 1'b1};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL single_count q%0d: got %b expected %b", i, obs, e);
         end
      end
      @(negedge CLK);
      e = {4'b0000, 4'b0001, 4'd3, 2'd0, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL single_done: got %b expected %b", obs, e);
      end
      REQ = '0;
      @(negedge CLK);
      e = {4'b0000, 4'b0000, 4'd3, 2'd0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL single_idle: got %b expected %b", obs, e);
      end
   endtask

   task automatic test_round_robin();
      logic [14:0] e;
      int order [5] = '{0, 1, 2, 3, 0};
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      LIMIT = {4'd1, 4'd1, 4'd1, 4'd1};
      REQ   = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            e = {4'(1 << order[n]), 4'b0000, 4'(c), 2'(order[n]), 1'b1};
            n_cmp++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL rr_grant n%0d c%0d: got %b expected %b", n, c, obs, e);
            end
         end
         @(negedge CLK);
         e = {4'b0000, 4'(1 << order[n]), 4'd1, 2'(order[n]), 1'b1};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL rr_release n%0d: got %b expected %b", n, obs, e);
         end
         if (n == 4) REQ = '0;
         @(negedge CLK);
         e = {4'b0000, 4'b0000, 4'd1, 2'(order[n]), 1'b0};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL rr_idle n%0d: got %b expected %b", n, obs, e);
         end
      end
   endtask

   task automatic test_zero_limit();
      logic [14:0] e;
      LIMIT = '0;
      REQ   = 4'b0100;
      @(negedge CLK);
      e = {4'b0100, 4'b0000, 4'd0, 2'd2, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL zero_grant: got %b expected %b", obs, e);
      end
      @(negedge CLK);
      e = {4'b0000, 4'b0100, 4'd0, 2'd2, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL zero_done: got %b expected %b", obs, e);
      end
      REQ = '0;
      @(negedge CLK);
      e = {4'b0000, 4'b0000, 4'd0, 2'd2, 1'b0};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL zero_idle: got %b expected %b", obs, e);
      end
   endtask

   task automatic test_abort();
      logic [14:0] e;
      LIMIT = {4'd0, 4'd0, 4'd15, 4'd0};
      REQ   = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         e = {4'b0010, 4'b0000, 4'(i), 2'd1, 1'b1};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL abort_count q%0d: got %b expected %b", i, obs, e);
         end
      end
      REQ = '0;
      @(negedge CLK);
      e = {4'b0000, 4'b0000, 4'd5, 2'd1, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL abort_release: got %b expected %b", obs, e);
      end
      REQ = 4'b1000;
      @(negedge CLK);
      e = {4'b0000, 4'b0000, 4'd5, 2'd1, 1'b0};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL abort_idle: got %b expected %b", obs, e);
      end
      @(negedge CLK);
      e = {4'b1000, 4'b0000, 4'd0, 2'd3, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL abort_next_grant: got %b expected %b", obs, e);
      end
      @(negedge CLK);
      e = {4'b0000, 4'b1000, 4'd0, 2'd3, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL abort_next_done: got %b expected %b", obs, e);
      end
      REQ = '0;
      @(negedge CLK);
   endtask

   task automatic test_max_limit();
      logic [14:0] e;
      LIMIT = {4'd0, 4'd0, 4'd0, 4'd15};
      REQ   = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         e = {4'b0001, 4'b0000, 4'(i), 2'd0, 1'b1};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL max_count q%0d: got %b expected %b", i, obs, e);
         end
         if (i == 1) LIMIT = {4'd0, 4'd0, 4'd0, 4'd2};
      end
      @(negedge CLK);
      e = {4'b0000, 4'b0001, 4'd15, 2'd0, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL max_done: got %b expected %b", obs, e);
      end
      REQ = '0;
      @(negedge CLK);
      e = {4'b0000, 4'b0000, 4'd15, 2'd0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL max_idle: got %b expected %b", obs, e);
      end
   endtask

   task automatic test_async_reset();
      logic [14:0] e;
      LIMIT = {4'd0, 4'd0, 4'd0, 4'd15};
      REQ   = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         e = {4'b0001, 4'b0000, 4'(i), 2'd0, 1'b1};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL arst_count q%0d: got %b expected %b", i, obs, e);
         end
      end
      #2;
      RESET = 1'b0;
      #1;
      e = {4'b0000, 4'b0000, 4'd0, 2'd0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL arst_immediate: got %b expected %b", obs, e);
      end
      REQ = 4'b0011;
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         e = {4'b0001, 4'b0000, 4'(i), 2'd0, 1'b1};
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL arst_regrant q%0d: got %b expected %b", i, obs, e);
         end
      end
      REQ = '0;
      @(negedge CLK);
      e = {4'b0000, 4'b0000, 4'd1, 2'd0, 1'b1};
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL arst_abort: got %b expected %b", obs, e);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_limit();
      test_abort();
      test_max_limit();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
